// File: rtl/wb_atomic_unit.sv
// Wishbone atomic unit: a 32-byte register window that turns reads of trigger
// offsets into locked read-modify-write bus sequences (CAS, FAA, SWAP).
//
// state | meaning
// IDLE  | bypass non-window traffic, decode window accesses
// REG   | one-cycle ack for TADDR/OPA/OPB access
// RD    | locked bus read of TADDR
// WR    | locked bus write of NEW to TADDR
// RESP  | one-cycle core ack (OLD) or rty
// ERR   | one-cycle core err
module wb_atomic_unit #(
    parameter int            DW        = 32,
    parameter int            AW        = 32,
    parameter logic [AW-1:0] BASE_ADDR = 32'h7fff_ffe0
) (
    input  logic            clk_i,
    input  logic            rst_ni,

    input  logic [AW-1:0]   wb_core_adr_i,
    input  logic [DW-1:0]   wb_core_dat_i,
    input  logic [DW/8-1:0] wb_core_sel_i,
    input  logic [1:0]      wb_core_bte_i,
    input  logic [2:0]      wb_core_cti_i,
    input  logic            wb_core_we_i,
    input  logic            wb_core_cyc_i,
    input  logic            wb_core_stb_i,
    output logic [DW-1:0]   wb_core_dat_o,
    output logic            wb_core_ack_o,
    output logic            wb_core_err_o,
    output logic            wb_core_rty_o,

    output logic [AW-1:0]   wb_bus_adr_o,
    output logic [DW-1:0]   wb_bus_dat_o,
    output logic [DW/8-1:0] wb_bus_sel_o,
    output logic [1:0]      wb_bus_bte_o,
    output logic [2:0]      wb_bus_cti_o,
    output logic            wb_bus_we_o,
    output logic            wb_bus_cyc_o,
    output logic            wb_bus_stb_o,
    input  logic [DW-1:0]   wb_bus_dat_i,
    input  logic            wb_bus_ack_i,
    input  logic            wb_bus_err_i,
    input  logic            wb_bus_rty_i
);

    typedef enum logic [2:0] {ST_IDLE, ST_REG, ST_RD, ST_WR, ST_RESP, ST_ERR} state_t;
    typedef enum logic [1:0] {OP_CAS, OP_FAA, OP_SWAP} op_t;

    state_t        state_q, state_d;
    op_t           op_q;
    logic [AW-1:0] taddr_q;
    logic [DW-1:0] opa_q, opb_q, old_q, new_q;
    logic [DW-1:0] new_val, reg_rdata;
    logic [1:0]    reg_sel_q;
    logic          rty_q;
    logic          win_hit, core_req, need_wr;
    logic [2:0]    win_off;

    assign win_hit  = (wb_core_adr_i[AW-1:5] == BASE_ADDR[AW-1:5]);
    assign win_off  = wb_core_adr_i[4:2];
    assign core_req = wb_core_cyc_i & wb_core_stb_i;

    always_comb begin
        new_val = opa_q;
        need_wr = 1'b1;
        case (op_q)
            OP_CAS: begin
                new_val = opb_q;
                need_wr = (wb_bus_dat_i == opa_q);
            end
            OP_FAA:  new_val = wb_bus_dat_i + opa_q;
            default: new_val = opa_q;
        endcase
    end

    always_comb begin
        reg_rdata = '0;
        case (reg_sel_q)
            2'd0:    reg_rdata = DW'(taddr_q);
            2'd1:    reg_rdata = opa_q;
            2'd2:    reg_rdata = opb_q;
            default: reg_rdata = '0;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        wb_bus_adr_o  = '0;
        wb_bus_dat_o  = '0;
        wb_bus_sel_o  = '0;
        wb_bus_bte_o  = '0;
        wb_bus_cti_o  = '0;
        wb_bus_we_o   = 1'b0;
        wb_bus_cyc_o  = 1'b0;
        wb_bus_stb_o  = 1'b0;
        wb_core_dat_o = '0;
        wb_core_ack_o = 1'b0;
        wb_core_err_o = 1'b0;
        wb_core_rty_o = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!win_hit) begin
                    wb_bus_adr_o  = wb_core_adr_i;
                    wb_bus_dat_o  = wb_core_dat_i;
                    wb_bus_sel_o  = wb_core_sel_i;
                    wb_bus_bte_o  = wb_core_bte_i;
                    wb_bus_cti_o  = wb_core_cti_i;
                    wb_bus_we_o   = wb_core_we_i;
                    wb_bus_cyc_o  = wb_core_cyc_i;
                    wb_bus_stb_o  = wb_core_stb_i;
                    wb_core_dat_o = wb_bus_dat_i;
                    // Same err > rty > ack priority as the FSM keeps responses exclusive
                    wb_core_err_o = wb_bus_err_i;
                    wb_core_rty_o = wb_bus_rty_i & ~wb_bus_err_i;
                    wb_core_ack_o = wb_bus_ack_i & ~wb_bus_err_i & ~wb_bus_rty_i;
                end else if (core_req) begin
                    if (win_off <= 3'd2)
                        state_d = ST_REG;
                    else if (win_off <= 3'd5 && !wb_core_we_i)
                        state_d = ST_RD;
                    else
                        state_d = ST_ERR;
                end
            end
            ST_REG: begin
                wb_core_ack_o = 1'b1;
                wb_core_dat_o = reg_rdata;
                state_d       = ST_IDLE;
            end
            ST_RD, ST_WR: begin
                wb_bus_cyc_o = 1'b1;
                wb_bus_stb_o = 1'b1;
                wb_bus_adr_o = taddr_q;
                wb_bus_sel_o = '1;
                if (state_q == ST_WR) begin
                    wb_bus_we_o  = 1'b1;
                    wb_bus_dat_o = new_q;
                end
                if (wb_bus_err_i)
                    state_d = ST_ERR;
                else if (wb_bus_rty_i)
                    state_d = ST_RESP;
                else if (wb_bus_ack_i)
                    state_d = (state_q == ST_RD && need_wr) ? ST_WR : ST_RESP;
            end
            ST_RESP: begin
                wb_core_dat_o = old_q;
                if (rty_q)
                    wb_core_rty_o = 1'b1;
                else
                    wb_core_ack_o = 1'b1;
                state_d = ST_IDLE;
            end
            ST_ERR: begin
                wb_core_err_o = 1'b1;
                state_d       = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // Abort an in-flight operation as soon as reset is seen, not one edge later
        if (!rst_ni && state_q != ST_IDLE) begin
            wb_core_ack_o = 1'b0;
            wb_core_err_o = 1'b0;
            wb_core_rty_o = 1'b0;
            wb_bus_cyc_o  = 1'b0;
            wb_bus_stb_o  = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            op_q      <= OP_CAS;
            taddr_q   <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
            old_q     <= '0;
            new_q     <= '0;
            reg_sel_q <= '0;
            rty_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    if (win_hit && core_req) begin
                        reg_sel_q <= win_off[1:0];
                        rty_q     <= 1'b0;
                        case (win_off)
                            3'd3:    op_q <= OP_CAS;
                            3'd4:    op_q <= OP_FAA;
                            default: op_q <= OP_SWAP;
                        endcase
                        if (wb_core_we_i) begin
                            case (win_off)
                                3'd0:    taddr_q <= AW'(wb_core_dat_i);
                                3'd1:    opa_q   <= wb_core_dat_i;
                                3'd2:    opb_q   <= wb_core_dat_i;
                                default: ;
                            endcase
                        end
                    end
                end
                ST_RD: begin
                    if (!wb_bus_err_i && !wb_bus_rty_i && wb_bus_ack_i) begin
                        old_q <= wb_bus_dat_i;
                        new_q <= new_val;
                    end
                end
                default: ;
            endcase
            if ((state_q == ST_RD || state_q == ST_WR) && !wb_bus_err_i && wb_bus_rty_i)
                rty_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_wb_atomic_unit.sv
// Bench for wb_atomic_unit: register table vectors, atomic sequences against a
// memory slave model with fault injection, bypass traffic and mid-operation reset.
module tb_wb_atomic_unit;

    localparam int          DW   = 32;
    localparam int          AW   = 32;
    localparam logic [31:0] BASE = 32'h7fff_ffe0;
    localparam logic [1:0]  R_NONE = 2'd0, R_ACK = 2'd1, R_ERR = 2'd2, R_RTY = 2'd3;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic [31:0]   core_adr, core_dat_w, core_dat_r;
    logic [3:0]    core_sel;
    logic [1:0]    core_bte;
    logic [2:0]    core_cti;
    logic          core_we, core_cyc, core_stb;
    logic          core_ack, core_err, core_rty;
    logic [31:0]   bus_adr, bus_dat_w;
    logic [31:0]   bus_dat_r = '0;
    logic [3:0]    bus_sel;
    logic [1:0]    bus_bte;
    logic [2:0]    bus_cti;
    logic          bus_we, bus_cyc, bus_stb;
    logic          bus_ack = 1'b0, bus_err = 1'b0, bus_rty = 1'b0;

    int errors = 0;
    int checks = 0;

    // Slave model state; modes: 0 ack, 1 err, 2 rty, 3 err+rty+ack, 4 rty+ack
    logic [31:0] mem [logic [31:0]];
    int          rd_mode = 0, wr_mode = 0;
    int          req_cnt = 0, wr_cnt = 0;
    int          smode;
    logic [31:0] last_adr = '0;
    logic [2:0]  last_cti = '0;
    logic [1:0]  last_bte = '0;
    logic [3:0]  last_sel = '0;

    typedef struct {
        logic        we;
        logic [31:0] off;
        logic [31:0] wdat;
        logic [1:0]  resp;
        logic [31:0] dat;
        bit          chk_dat;
    } vec_t;
    vec_t vecs[$];

    typedef struct {
        logic [1:0]  resp;
        logic [31:0] dat;
        bit          chk_dat;
    } exp_t;
    exp_t sb[$];

    wb_atomic_unit #(.DW(DW), .AW(AW), .BASE_ADDR(BASE)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .wb_core_adr_i(core_adr), .wb_core_dat_i(core_dat_w), .wb_core_sel_i(core_sel),
        .wb_core_bte_i(core_bte), .wb_core_cti_i(core_cti), .wb_core_we_i(core_we),
        .wb_core_cyc_i(core_cyc), .wb_core_stb_i(core_stb), .wb_core_dat_o(core_dat_r),
        .wb_core_ack_o(core_ack), .wb_core_err_o(core_err), .wb_core_rty_o(core_rty),
        .wb_bus_adr_o(bus_adr), .wb_bus_dat_o(bus_dat_w), .wb_bus_sel_o(bus_sel),
        .wb_bus_bte_o(bus_bte), .wb_bus_cti_o(bus_cti), .wb_bus_we_o(bus_we),
        .wb_bus_cyc_o(bus_cyc), .wb_bus_stb_o(bus_stb), .wb_bus_dat_i(bus_dat_r),
        .wb_bus_ack_i(bus_ack), .wb_bus_err_i(bus_err), .wb_bus_rty_i(bus_rty)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    always @(posedge clk_i) begin
        bus_ack <= 1'b0;
        bus_err <= 1'b0;
        bus_rty <= 1'b0;
        if (bus_cyc && bus_stb && !(bus_ack || bus_err || bus_rty)) begin
            smode    = bus_we ? wr_mode : rd_mode;
            req_cnt  = req_cnt + 1;
            last_adr <= bus_adr;
            last_cti <= bus_cti;
            last_bte <= bus_bte;
            last_sel <= bus_sel;
            bus_dat_r <= mem_rd(bus_adr);
            case (smode)
                1: bus_err <= 1'b1;
                2: bus_rty <= 1'b1;
                3: begin bus_err <= 1'b1; bus_rty <= 1'b1; bus_ack <= 1'b1; end
                4: begin bus_rty <= 1'b1; bus_ack <= 1'b1; end
                default: bus_ack <= 1'b1;
            endcase
            if (bus_we && smode == 0) begin
                mem[bus_adr] = bus_dat_w;
                wr_cnt = wr_cnt + 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic addv(input logic we, input logic [31:0] off, input logic [31:0] wdat,
                        input logic [1:0] resp, input logic [31:0] dat, input bit c);
        vec_t v;
        v.we = we; v.off = off; v.wdat = wdat; v.resp = resp; v.dat = dat; v.chk_dat = c;
        vecs.push_back(v);
    endtask

    task automatic core_access(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                               input logic [2:0] cti, input bit atomic,
                               output logic [1:0] resp, output logic [31:0] rdat,
                               output bit gap, output bit multi);
        bit seen;
        @(negedge clk_i);
        core_adr = adr; core_dat_w = dat; core_we = we; core_cti = cti; core_bte = 2'b00;
        core_cyc = 1'b1; core_stb = 1'b1;
        resp = R_NONE; rdat = '0; gap = 1'b0; multi = 1'b0; seen = 1'b0;
        for (int i = 0; i < 20 && resp == R_NONE; i++) begin
            @(posedge clk_i);
            #1;
            if (atomic && seen && !bus_cyc && !(core_ack || core_err || core_rty)) gap = 1'b1;
            if (bus_cyc) seen = 1'b1;
            if ((core_ack && core_err) || (core_ack && core_rty) || (core_err && core_rty)) multi = 1'b1;
            if (core_err)      resp = R_ERR;
            else if (core_rty) resp = R_RTY;
            else if (core_ack) resp = R_ACK;
            rdat = core_dat_r;
        end
        core_cyc = 1'b0; core_stb = 1'b0; core_we = 1'b0; core_cti = 3'b000;
    endtask

    task automatic do_access(input string name, input logic we, input logic [31:0] adr,
                             input logic [31:0] wdat, input logic [2:0] cti,
                             input logic [1:0] exp_resp, input logic [31:0] exp_dat,
                             input bit chk_dat, input bit atomic);
        exp_t        e;
        logic [1:0]  resp;
        logic [31:0] rdat;
        bit          gap, multi;
        e.resp = exp_resp; e.dat = exp_dat; e.chk_dat = chk_dat;
        sb.push_back(e);
        core_access(we, adr, wdat, cti, atomic, resp, rdat, gap, multi);
        e = sb.pop_front();
        chk({name, "_resp"}, 32'(resp), 32'(e.resp));
        if (e.chk_dat) chk({name, "_dat"}, rdat, e.dat);
        chk({name, "_excl"}, 32'(multi), 32'd0);
        if (atomic) chk({name, "_lock"}, 32'(gap), 32'd0);
        @(posedge clk_i);
        #1;
        chk({name, "_onecyc"}, {29'd0, core_ack, core_err, core_rty}, 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0, r0;
        rst_ni = 1'b0;
        core_adr = '0; core_dat_w = '0; core_sel = 4'hF; core_bte = '0; core_cti = '0;
        core_we = 1'b0; core_cyc = 1'b0; core_stb = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_core_resp", {29'd0, core_ack, core_err, core_rty}, 32'd0);
        chk("rst_bus_cyc", {30'd0, bus_cyc, bus_stb}, 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // sel deliberately partial: register writes must still be full-word
        core_sel = 4'h1;
        addv(1'b0, 32'h00, 32'h0,     R_ACK, 32'h0,   1'b1);
        addv(1'b0, 32'h08, 32'h0,     R_ACK, 32'h0,   1'b1);
        addv(1'b1, 32'h00, 32'h100,   R_ACK, 32'h0,   1'b0);
        addv(1'b1, 32'h04, 32'h5,     R_ACK, 32'h0,   1'b0);
        addv(1'b1, 32'h08, 32'h9,     R_ACK, 32'h0,   1'b0);
        addv(1'b0, 32'h00, 32'h0,     R_ACK, 32'h100, 1'b1);
        addv(1'b0, 32'h04, 32'h0,     R_ACK, 32'h5,   1'b1);
        addv(1'b0, 32'h08, 32'h0,     R_ACK, 32'h9,   1'b1);
        addv(1'b1, 32'h0C, 32'hDEAD,  R_ERR, 32'h0,   1'b0);
        addv(1'b1, 32'h14, 32'hDEAD,  R_ERR, 32'h0,   1'b0);
        addv(1'b0, 32'h18, 32'h0,     R_ERR, 32'h0,   1'b0);
        addv(1'b1, 32'h1C, 32'h1,     R_ERR, 32'h0,   1'b0);
        addv(1'b0, 32'h04, 32'h0,     R_ACK, 32'h5,   1'b1);
        addv(1'b0, 32'h08, 32'h0,     R_ACK, 32'h9,   1'b1);
        r0 = req_cnt;
        for (int i = 0; i < vecs.size(); i++)
            do_access($sformatf("vec%0d", i), vecs[i].we, BASE + vecs[i].off, vecs[i].wdat,
                      3'b000, vecs[i].resp, vecs[i].dat, vecs[i].chk_dat, 1'b0);
        chk("reg_no_bus", 32'(req_cnt - r0), 32'd0);
        core_sel = 4'hF;

        mem[32'h100] = 32'h5;
        w0 = wr_cnt;
        do_access("cas_hit", 1'b0, BASE + 32'h0C, 32'h0, 3'b000, R_ACK, 32'h5, 1'b1, 1'b1);
        chk("cas_hit_mem", mem_rd(32'h100), 32'h9);
        chk("cas_hit_wrs", 32'(wr_cnt - w0), 32'd1);

        mem[32'h100] = 32'h7;
        w0 = wr_cnt;
        do_access("cas_miss", 1'b0, BASE + 32'h0C, 32'h0, 3'b000, R_ACK, 32'h7, 1'b1, 1'b1);
        chk("cas_miss_mem", mem_rd(32'h100), 32'h7);
        chk("cas_miss_wrs", 32'(wr_cnt - w0), 32'd0);

        do_access("opa2", 1'b1, BASE + 32'h04, 32'h2, 3'b000, R_ACK, 32'h0, 1'b0, 1'b0);
        mem[32'h100] = 32'hFFFF_FFFF;
        do_access("faa_wrap", 1'b0, BASE + 32'h10, 32'h0, 3'b000, R_ACK, 32'hFFFF_FFFF, 1'b1, 1'b1);
        chk("faa_wrap_mem", mem_rd(32'h100), 32'h1);

        mem[32'h100] = 32'h1234;
        do_access("swap", 1'b0, BASE + 32'h14, 32'h0, 3'b000, R_ACK, 32'h1234, 1'b1, 1'b1);
        chk("swap_mem", mem_rd(32'h100), 32'h2);

        mem[32'h100] = 32'hAAAA;
        wr_mode = 1;
        do_access("swap_wrerr", 1'b0, BASE + 32'h14, 32'h0, 3'b000, R_ERR, 32'h0, 1'b0, 1'b1);
        wr_mode = 0;
        chk("swap_wrerr_mem", mem_rd(32'h100), 32'hAAAA);
        do_access("after_err", 1'b0, BASE + 32'h04, 32'h0, 3'b000, R_ACK, 32'h2, 1'b1, 1'b0);

        w0 = wr_cnt;
        rd_mode = 2;
        do_access("faa_rdrty", 1'b0, BASE + 32'h10, 32'h0, 3'b000, R_RTY, 32'h0, 1'b0, 1'b1);
        rd_mode = 3;
        do_access("cas_errprio", 1'b0, BASE + 32'h0C, 32'h0, 3'b000, R_ERR, 32'h0, 1'b0, 1'b1);
        rd_mode = 4;
        do_access("swap_rtyprio", 1'b0, BASE + 32'h14, 32'h0, 3'b000, R_RTY, 32'h0, 1'b0, 1'b1);
        rd_mode = 0;
        chk("fault_no_wr", 32'(wr_cnt - w0), 32'd0);
        chk("fault_mem", mem_rd(32'h100), 32'hAAAA);

        mem[32'h200] = 32'hCAFE_0001;
        core_sel = 4'h3;
        do_access("byp_burst", 1'b0, 32'h200, 32'h0, 3'b010, R_ACK, 32'hCAFE_0001, 1'b1, 1'b0);
        chk("byp_cti", 32'(last_cti), 32'h2);
        chk("byp_bte", 32'(last_bte), 32'h0);
        chk("byp_adr", last_adr, 32'h200);
        chk("byp_sel", 32'(last_sel), 32'h3);
        core_sel = 4'hF;
        do_access("byp_wr", 1'b1, 32'h204, 32'hBEEF_0002, 3'b000, R_ACK, 32'h0, 1'b0, 1'b0);
        chk("byp_wr_mem", mem_rd(32'h204), 32'hBEEF_0002);
        rd_mode = 1;
        do_access("byp_err", 1'b0, 32'h300, 32'h0, 3'b000, R_ERR, 32'h0, 1'b0, 1'b0);
        rd_mode = 3;
        do_access("byp_prio", 1'b0, 32'h300, 32'h0, 3'b000, R_ERR, 32'h0, 1'b0, 1'b0);
        rd_mode = 0;

        r0 = req_cnt;
        do_access("wr_trig", 1'b1, BASE + 32'h0C, 32'h55, 3'b000, R_ERR, 32'h0, 1'b0, 1'b0);
        chk("wr_trig_nobus", 32'(req_cnt - r0), 32'd0);

        // Reset while the locked read is outstanding
        w0 = wr_cnt;
        @(negedge clk_i);
        core_adr = BASE + 32'h10; core_we = 1'b0; core_cyc = 1'b1; core_stb = 1'b1;
        @(posedge clk_i);
        #1;
        chk("rst_rd_cyc", 32'(bus_cyc), 32'd1);
        rst_ni = 1'b0;
        @(posedge clk_i);
        #1;
        chk("rst_abort_bus", {30'd0, bus_cyc, bus_stb}, 32'd0);
        chk("rst_abort_core", {29'd0, core_ack, core_err, core_rty}, 32'd0);
        core_cyc = 1'b0; core_stb = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_no_wr", 32'(wr_cnt - w0), 32'd0);
        do_access("rst_taddr", 1'b0, BASE + 32'h00, 32'h0, 3'b000, R_ACK, 32'h0, 1'b1, 1'b0);
        do_access("rst_opa", 1'b0, BASE + 32'h04, 32'h0, 3'b000, R_ACK, 32'h0, 1'b1, 1'b0);
        do_access("rst_opb", 1'b0, BASE + 32'h08, 32'h0, 3'b000, R_ACK, 32'h0, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
